// File: rtl/seg7_pkg.sv
// Shared widths and active-low segment codes (bit6 = a ... bit0 = g).
package seg7_pkg;
  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0001101;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b1100000;
  localparam logic [SEG_W-1:0] SEG_C = 7'b0110001;
  localparam logic [SEG_W-1:0] SEG_D = 7'b1000010;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0111000;
endpackage

// File: rtl/seg7_if.sv
// Display bus: data/control toward the scanner, drive lines back out.
interface seg7_if #(parameter int NDIGIT = 4);
  logic [seg7_pkg::NIB_W*NDIGIT-1:0] digits;
  logic [NDIGIT-1:0]                 dp;
  logic                              load;
  logic [NDIGIT-1:0]                 blink_mask;
  logic                              hex_mode;
  logic                              blank_lz;
  logic [seg7_pkg::SEG_W-1:0]        seg;
  logic                              dp_n;
  logic [NDIGIT-1:0]                 an_n;

  modport master (output digits, dp, load, blink_mask, hex_mode, blank_lz,
                  input  seg, dp_n, an_n);
  modport slave  (input  digits, dp, load, blink_mask, hex_mode, blank_lz,
                  output seg, dp_n, an_n);
endinterface

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern; non-decimal values blank unless hex.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic             hex_mode,
  output logic [SEG_W-1:0] seg
);
  // pure lookup
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: prescaled digit rotation, ghosting guard,
// leading-zero blanking and framewise blink, all outputs registered.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIGIT       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic  clk,
  input  logic  rst_n,
  seg7_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]                  presc;
  logic [IW-1:0]                  idx;
  logic [FW-1:0]                  fcnt;
  logic                           phase;
  logic                           tick, frame_end;
  logic [NDIGIT-1:0][NIB_W-1:0]   sh_dig;
  logic [NDIGIT-1:0]              sh_dp, sh_blk;
  logic [NDIGIT-1:0]              lz;
  logic                           lz_acc;
  logic                           blank;
  logic [SEG_W-1:0]               dec_seg;

  assign tick      = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == IW'(NDIGIT - 1));

  // prescaler: free-running 0..SCAN_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // digit index advances once per tick, wrapping at the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         idx <= '0;
    else if (frame_end) idx <= '0;
    else if (tick)      idx <= idx + 1'b1;
  end

  // blink phase flips after every BLINK_FRAMES completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (frame_end) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // shadow registers; scan timing is independent of load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_dig <= '0;
      sh_dp  <= '0;
      sh_blk <= '0;
    end else if (bus.load) begin
      sh_dig <= bus.digits;
      sh_dp  <= bus.dp;
      sh_blk <= bus.blink_mask;
    end
  end

  // lz[i]: shadow digits i..NDIGIT-1 are all zero
  always_comb begin
    lz     = '0;
    lz_acc = 1'b1;
    for (int i = NDIGIT - 1; i >= 0; i--) begin
      lz_acc = lz_acc & (sh_dig[i] == '0);
      lz[i]  = lz_acc;
    end
  end

  assign blank = (bus.blank_lz && (idx != '0) && lz[idx]) ||
                 (phase && sh_blk[idx]);

  seg7_decode u_dec (
    .nib      (sh_dig[idx]),
    .hex_mode (bus.hex_mode),
    .seg      (dec_seg)
  );

  // output register; anodes all off for the cycle after each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg  <= SEG_BLANK;
      bus.dp_n <= 1'b1;
      bus.an_n <= '1;
    end else begin
      bus.seg  <= blank ? SEG_BLANK : dec_seg;
      bus.dp_n <= blank | ~sh_dp[idx];
      bus.an_n <= tick ? '1 : ~(NDIGIT'(1) << idx);
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with NDIGIT=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Edge k after reset release: slot t=k-1, digit (t/4)%4, guard when t%4==3,
// frame t/16; blink phase is 1 in frames 2,3,6,7.
module tb_seg7_scan;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   k = 0;

  always #5 clk = ~clk;

  seg7_if #(.NDIGIT(ND)) bus ();

  seg7_scan #(.NDIGIT(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic goto_k(input int target);
    while (k < target) adv(1);
  endtask

  initial begin
    logic [6:0] scan_code [0:3];
    logic [3:0] an_exp;
    scan_code = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

    bus.digits     = 16'h4321;
    bus.dp         = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.load       = 1'b1;
    bus.hex_mode   = 1'b0;
    bus.blank_lz   = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_seg", 16'(bus.seg), 16'b1111111);
    chk("rst_dp_n", 16'(bus.dp_n), 16'b1);
    chk("rst_an_n", 16'(bus.an_n), 16'b1111);

    rst_n = 1'b1;
    k = 0;

    // scan order, 3-cycle selects with one guard cycle each
    for (int d = 0; d < 4; d++) begin
      an_exp = ~(4'b0001 << d);
      goto_k(4*d + 1);
      chk("scan_an_first", 16'(bus.an_n), 16'(an_exp));
      if (d == 0) bus.load = 1'b0;
      goto_k(4*d + 3);
      chk("scan_an_last", 16'(bus.an_n), 16'(an_exp));
      chk("scan_seg", 16'(bus.seg), 16'(scan_code[d]));
      chk("scan_dp_n", 16'(bus.dp_n), 16'b1);
      goto_k(4*d + 4);
      chk("scan_guard", 16'(bus.an_n), 16'b1111);
    end

    // decode modes on digit 0 = A (frame 1)
    bus.load = 1'b1;
    bus.digits = 16'h432A;
    adv(1);
    bus.load = 1'b0;
    chk("dec_old", 16'(bus.seg), 16'b1001111);
    adv(1);
    chk("dec_A_dec", 16'(bus.seg), 16'b1111111);
    bus.hex_mode = 1'b1;
    adv(1);
    chk("dec_A_hex", 16'(bus.seg), 16'b0001000);

    // load pulse inside digit 1's window
    goto_k(21);
    chk("ld_an", 16'(bus.an_n), 16'b1101);
    chk("ld_seg_pre", 16'(bus.seg), 16'b0010010);
    bus.load = 1'b1;
    bus.digits = 16'h437A;
    adv(1);
    bus.load = 1'b0;
    chk("ld_seg_old", 16'(bus.seg), 16'b0010010);
    adv(1);
    chk("ld_seg_new", 16'(bus.seg), 16'b0001101);
    chk("ld_an_kept", 16'(bus.an_n), 16'b1101);
    adv(1);
    chk("ld_guard", 16'(bus.an_n), 16'b1111);

    // leading-zero blanking (frames 2-3)
    goto_k(32);
    bus.load = 1'b1;
    bus.digits = 16'h0050;
    bus.blank_lz = 1'b1;
    bus.hex_mode = 1'b0;
    adv(1);
    bus.load = 1'b0;
    goto_k(35); chk("lz_d0", 16'(bus.seg), 16'b0000001);
    goto_k(39); chk("lz_d1", 16'(bus.seg), 16'b0100100);
    goto_k(43); chk("lz_d2", 16'(bus.seg), 16'b1111111);
    chk("lz_d2_dp", 16'(bus.dp_n), 16'b1);
    goto_k(47); chk("lz_d3", 16'(bus.seg), 16'b1111111);
    bus.blank_lz = 1'b0;
    goto_k(63);
    chk("nolz_d3", 16'(bus.seg), 16'b0000001);
    chk("nolz_an", 16'(bus.an_n), 16'b0111);

    // blink digit 0 with its decimal point (frames 4-8)
    goto_k(64);
    bus.load = 1'b1;
    bus.digits = 16'h4321;
    bus.dp = 4'b0001;
    bus.blink_mask = 4'b0001;
    adv(1);
    bus.load = 1'b0;
    goto_k(67);  chk("bl_f4_seg", 16'(bus.seg), 16'b1001111);
    chk("bl_f4_dp", 16'(bus.dp_n), 16'b0);
    goto_k(83);  chk("bl_f5_seg", 16'(bus.seg), 16'b1001111);
    chk("bl_f5_dp", 16'(bus.dp_n), 16'b0);
    goto_k(99);  chk("bl_f6_seg", 16'(bus.seg), 16'b1111111);
    chk("bl_f6_dp", 16'(bus.dp_n), 16'b1);
    chk("bl_f6_an", 16'(bus.an_n), 16'b1110);
    goto_k(103); chk("bl_f6_d1", 16'(bus.seg), 16'b0010010);
    goto_k(115); chk("bl_f7_seg", 16'(bus.seg), 16'b1111111);
    goto_k(131); chk("bl_f8_seg", 16'(bus.seg), 16'b1001111);
    chk("bl_f8_dp", 16'(bus.dp_n), 16'b0);

    // asynchronous reset while digit 2 is selected
    goto_k(138);
    chk("mid_an", 16'(bus.an_n), 16'b1011);
    rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(bus.an_n), 16'b1111);
    chk("arst_seg", 16'(bus.seg), 16'b1111111);
    chk("arst_dp", 16'(bus.dp_n), 16'b1);
    adv(2);
    rst_n = 1'b1;
    k = 0;
    adv(1);
    chk("post_an", 16'(bus.an_n), 16'b1110);
    chk("post_seg", 16'(bus.seg), 16'b0000001);
    chk("post_dp", 16'(bus.dp_n), 16'b1);
    goto_k(4); chk("post_guard", 16'(bus.an_n), 16'b1111);
    goto_k(5); chk("post_d1", 16'(bus.an_n), 16'b1101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
